// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt-controller state encoding and stack/flag widths.
package cpu_pkg;

  localparam int FLAGS_W = 3;
  localparam int STACK_W = 16;

  typedef enum logic [2:0] {
    IC_IDLE    = 3'd0,
    IC_DRAIN   = 3'd1,
    IC_PUSH_HI = 3'd2,
    IC_PUSH_LO = 3'd3,
    IC_PUSH_FL = 3'd4,
    IC_VECTOR  = 3'd5,
    IC_ACTIVE  = 3'd6
  } ic_state_e;

  // Zero-extend the {C,N,Z} flags to one stack word.
  function automatic logic [STACK_W-1:0] flags_word(input logic [FLAGS_W-1:0] flags);
    return {{(STACK_W - FLAGS_W){1'b0}}, flags};
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the interrupt line plus the sticky pending bit.
// A clear in the same cycle as a new edge wins, so the edge merges into
// the entry that is being taken.
module irq_edge_latch (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pending
);

  logic irq_q;
  logic irq_d;
  logic pending_q;
  logic pending_d;

  // Edge detect and pending set/clear.
  always_comb begin
    irq_d     = i_irq;
    pending_d = pending_q;
    if (i_irq & ~irq_q) pending_d = 1'b1;
    if (i_clr)          pending_d = 1'b0;
  end

  // Request registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
    end
  end

  assign o_pending = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Hardware-interrupt entry sequencer: drains the pipeline, pushes the resume
// PC (high then low half) and the flags through a handshaked stack port,
// redirects fetch to the vector and tracks in-service state until RTI.
module interrupt_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_irq,
  input  logic                 i_exm_busy,
  input  logic                 i_branch_pending,
  input  logic                 i_rti,
  input  logic [31:0]          i_pc_resume,
  input  logic [FLAGS_W-1:0]   i_flags,
  input  logic                 i_push_ack,
  output logic                 o_stall_fetch,
  output logic                 o_flush_f_d,
  output logic                 o_push_req,
  output logic [STACK_W-1:0]   o_push_data,
  output logic                 o_pc_load,
  output logic [31:0]          o_pc_new,
  output logic                 o_int_active,
  output logic                 o_irq_pending
);

  // A zero drain length still needs one quiet cycle to sample a stable PC.
  localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int CNT_W     = $clog2(DRAIN_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_EFF);

  ic_state_e            state_q, state_d;
  logic [CNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [31:0]          pc_saved_q, pc_saved_d;
  logic [FLAGS_W-1:0]   flags_saved_q, flags_saved_d;
  logic                 pending;
  logic                 pending_clr;
  logic                 quiet;

  irq_edge_latch u_irq_edge_latch (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_irq     (i_irq),
    .i_clr     (pending_clr),
    .o_pending (pending)
  );

  assign quiet         = ~(i_exm_busy | i_branch_pending);
  assign o_irq_pending = pending;

  // Next-state, drain counting, PC/flags capture and all sequencer outputs.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    pc_saved_d    = pc_saved_q;
    flags_saved_d = flags_saved_q;
    pending_clr   = 1'b0;
    o_stall_fetch = 1'b0;
    o_flush_f_d   = 1'b0;
    o_push_req    = 1'b0;
    o_push_data   = '0;
    o_pc_load     = 1'b0;
    o_pc_new      = '0;
    o_int_active  = 1'b0;

    case (state_q)
      IC_IDLE: begin
        if (pending) begin
          state_d       = IC_DRAIN;
          pending_clr   = 1'b1;
          o_flush_f_d   = 1'b1;
          o_stall_fetch = 1'b1;
          drain_cnt_d   = '0;
        end
      end

      IC_DRAIN: begin
        o_stall_fetch = 1'b1;
        if (!quiet) begin
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = (drain_cnt_q == CNT_MAX) ? CNT_MAX : drain_cnt_q + CNT_W'(1);
          // Fetch keeps i_pc_resume current, so this is the post-branch PC.
          if (drain_cnt_q == CNT_LAST) begin
            pc_saved_d    = i_pc_resume;
            flags_saved_d = i_flags;
            state_d       = IC_PUSH_HI;
          end
        end
      end

      IC_PUSH_HI: begin
        o_stall_fetch = 1'b1;
        o_push_req    = 1'b1;
        o_push_data   = pc_saved_q[31:16];
        if (i_push_ack) state_d = IC_PUSH_LO;
      end

      IC_PUSH_LO: begin
        o_stall_fetch = 1'b1;
        o_push_req    = 1'b1;
        o_push_data   = pc_saved_q[15:0];
        if (i_push_ack) state_d = IC_PUSH_FL;
      end

      IC_PUSH_FL: begin
        o_stall_fetch = 1'b1;
        o_push_req    = 1'b1;
        o_push_data   = flags_word(flags_saved_q);
        if (i_push_ack) state_d = IC_VECTOR;
      end

      IC_VECTOR: begin
        o_pc_load = 1'b1;
        o_pc_new  = VECTOR_ADDR;
        state_d   = IC_ACTIVE;
      end

      IC_ACTIVE: begin
        o_int_active = 1'b1;
        if (i_rti) state_d = IC_IDLE;
      end

      default: state_d = IC_IDLE;
    endcase
  end

  // Sequencer state; reset abandons any in-flight push.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IC_IDLE;
      drain_cnt_q   <= '0;
      pc_saved_q    <= '0;
      flags_saved_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      pc_saved_q    <= pc_saved_d;
      flags_saved_q <= flags_saved_d;
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Sequences hardware-interrupt entry for the 5-stage pipeline. The block sits beside `hazard_unit` and replaces the constant-zero interrupt inputs of the fetch and decode stages. On an accepted interrupt it:
- stalls fetch and drains the pipeline,
- pushes the resume PC and the flags through a handshaked stack-write port,
- redirects fetch to a fixed vector.

It then tracks in-service state until RTI retires. Nesting is blocked; one further request is held pending.

## Interface
Parameters:
- `VECTOR_ADDR`, default 32'h0000_0000: PC loaded on interrupt entry.
- `DRAIN_CYCLES`, default 2: number of consecutive quiet cycles required before pushing.

Ports:
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_irq` in 1: external interrupt request; a rising edge is a request.
- `i_exm_busy` in 1: EXM holds a valid or multi-cycle op (the hazard unit's `o_state`, OR'd with EXM valid).
- `i_branch_pending` in 1: a branch decision, push_pc or pop_pc is active in EXM.
- `i_rti` in 1: single-cycle pulse when RTI completes in EXM.
- `i_pc_resume` in 32: PC of the oldest unexecuted instruction, as held by fetch.
- `i_flags` in 3: current CCR {C,N,Z}.
- `i_push_ack` in 1: stack port accepted the current word.
- `o_stall_fetch` out 1: hold PC and F/D buffer.
- `o_flush_f_d` out 1: clear the F/D buffer.
- `o_push_req` out 1: request a stack write.
- `o_push_data` out 16: word to push.
- `o_pc_load` out 1: one-cycle strobe forcing PC to `o_pc_new`.
- `o_pc_new` out 32: redirect target.
- `o_int_active` out 1: interrupt is in service.
- `o_irq_pending` out 1: a request is latched but not yet taken.

## Operation
Request capture:
- `irq_q` registers `i_irq`; a request is `i_irq & ~irq_q`.
- A request sets `pending`. `pending` clears on the IDLE→DRAIN transition.
- `o_irq_pending` = `pending`.

States and transitions:
- **IDLE**: if `pending`, go to DRAIN. In the transition cycle assert `o_flush_f_d` and `o_stall_fetch`, and load `drain_cnt` = 0.
- **DRAIN**:
  - `o_stall_fetch` = 1.
  - If `i_exm_busy | i_branch_pending`, then `drain_cnt` ← 0. Otherwise `drain_cnt` ← `drain_cnt` + 1, saturating at `DRAIN_CYCLES`.
  - When `drain_cnt` == `DRAIN_CYCLES`−1 and the current cycle is quiet: capture `pc_saved` ← `i_pc_resume` and `flags_saved` ← `i_flags`, then go to PUSH_HI.
  - Fetch keeps updating `i_pc_resume` if a branch resolves during drain, so the captured value is the post-branch PC.
- **PUSH_HI**: `o_push_req` = 1, `o_push_data` = `pc_saved[31:16]`. On `i_push_ack`, go to PUSH_LO.
- **PUSH_LO**: `o_push_data` = `pc_saved[15:0]`. On ack, go to PUSH_FL.
- **PUSH_FL**: `o_push_data` = {13'b0, `flags_saved`}. On ack, go to VECTOR.
- **VECTOR**: `o_pc_load` = 1, `o_pc_new` = `VECTOR_ADDR`, `o_stall_fetch` = 0. Next state is ACTIVE.
- **ACTIVE**: `o_int_active` = 1. On `i_rti`, go to IDLE. Requests arriving here only set `pending`.

Push handshake rules:
- `o_stall_fetch` = 1 in all PUSH states.
- `o_push_data` holds stable while `o_push_req` is high and no ack has arrived.
- Exactly one word is written per ack.
- `i_push_ack` is ignored outside the PUSH states.

Boundary cases:
- A request edge in the same cycle as `i_rti` in ACTIVE: `pending` is set and the state goes to IDLE. DRAIN is entered on the next cycle.
- A request edge while `pending` is already 1: merged; only one entry occurs.
- A request edge during DRAIN, PUSH or VECTOR: sets `pending`, which is serviced after the following RTI.
- `i_rti` outside ACTIVE: ignored.
- `i_reset` in any state, applied synchronously:
  - state → IDLE;
  - `pending`, `irq_q`, `drain_cnt`, `pc_saved` and `flags_saved` → 0;
  - an in-flight push is abandoned.
- A `DRAIN_CYCLES` value of 0 behaves as 1.

## Timing
- Reset value of all outputs: 0. `o_pc_new` = 0 except in VECTOR.
- An edge on `i_irq` in cycle t sets `pending` at t+1, so DRAIN is entered at t+2 at the earliest.
- `o_flush_f_d` is high for exactly one cycle per entry.
- Minimum time from DRAIN entry to VECTOR, with acks returned in the same cycle: `DRAIN_CYCLES` + 3 cycles.
- `o_pc_load` pulses for exactly one cycle. Fetch uses `o_pc_new` in that cycle.
- `o_int_active` rises the cycle after VECTOR and falls the cycle after `i_rti`.

## Structure
- A shared package `cpu_pkg` holds:
  - the state enum `IC_IDLE`…`IC_ACTIVE` (3 bits);
  - the flags width constant `FLAGS_W` = 3;
  - the stack word width `STACK_W` = 16.
- `VECTOR_ADDR` stays a module parameter.
- One natural sub-module: `irq_edge_latch`, which provides edge detection and the pending register with clear.
- The top level instantiates the controller alongside `hazard_unit`. The top level ORs `o_flush_f_d` into `reset_f_d` and `o_stall_fetch` into fetch's hold.

## Test plan
- **Basic entry:** idle pipeline, `i_pc_resume` = 32'h0000_0124, `i_flags` = 3'b101, ack tied high, edge on `i_irq`. Expected:
  - pushes 16'h0000, then 16'h0124, then 16'h0005;
  - `o_pc_load` with `o_pc_new` = `VECTOR_ADDR`, exactly `DRAIN_CYCLES` + 3 cycles after DRAIN entry;
  - `o_int_active` = 1 on the following cycle.
- **Drain restart:** `i_exm_busy` high for 4 cycles after DRAIN entry. The first push occurs only after 2 consecutive quiet cycles. `pc_saved` equals an `i_pc_resume` updated during drain (e.g. a branch sets it to 32'h0000_0040), giving a pushed low word of 16'h0040.
- **Slow ack:** `i_push_ack` asserted only every 3rd cycle. `o_push_data` stays stable between acks, exactly three words are pushed, and VECTOR follows the third ack.
- **Nested request:** a second `i_irq` edge while ACTIVE. `o_irq_pending` = 1, with no flush and no push. After an `i_rti` pulse, the state goes IDLE then DRAIN, and a second full entry occurs.
- **Same-cycle RTI and edge:** an `i_rti` pulse coincident with an `i_irq` edge. Expected: IDLE at t+1, DRAIN at t+2, with exactly one entry.
- **Reset mid-push:** `i_reset` asserted in PUSH_LO. On the next cycle all outputs are 0 and the state is IDLE. A stale `i_push_ack` is ignored, and the next request restarts from PUSH_HI.
